if_id_buf: RTL and testbench
============================

Name: if_id_buf

Overview:
- Buffers fetched instructions between the fetch stage and the decode stage.
- Holds up to DEPTH entries; each entry is an {instr, PC2} pair.
- Drives fetch's pcWrite, so the PC advances only when an entry is accepted.
- Absorbs decode stalls, squashes its contents on a branch/jump flush, and stops accepting entries once a HALT has been buffered.

Parameters:
- DEPTH, 2, number of entries; power of two, minimum 2.
- NOP_INSTR, 16'h0800, instruction presented to decode when the buffer is empty.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-low reset (0 = in reset).
- instr_in  input  16  instruction from fetch memory for the current PC.
- pc2_in  input  16  currentPC + 2 from fetch.
- fetch_valid  input  1  fetch presents a valid instruction this cycle.
- flush  input  1  redirect from the branch/jump resolve stage; squashes all entries.
- dec_ready  input  1  decode consumes the head entry this cycle.
- pcWrite  output  1  to fetch: advance the PC; high exactly when a push occurs.
- instr_out  output  16  head instruction; NOP_INSTR when empty.
- pc2_out  output  16  head PC2; 16'h0000 when empty.
- valid_out  output  1  head entry is valid.
- halt_seen  output  1  a HALT has been accepted since the last reset or flush.
- count  output  $clog2(DEPTH)+1  number of occupied entries.
- stall_cnt  output  16  stall statistic (see Optional Feature).

Behaviour:
- Reset (rst=0, asynchronous):
  - Clears the head/tail pointers, count and halt_seen.
  - Outputs: valid_out=0, instr_out=NOP_INSTR, pc2_out=0, pcWrite=0, stall_cnt=0.
  - Entry storage need not be cleared.
- The buffer is a circular FIFO. Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- pop = valid_out & dec_ready & ~flush.
- push = fetch_valid & ~halt_seen & ~flush & (count<DEPTH | pop).
  - A push into a full buffer is therefore allowed in the same cycle as a pop.
- pcWrite = push. This is combinational from dec_ready, flush and fetch_valid; no registered delay.
- count_next = count + push - pop. count never exceeds DEPTH and never underflows.
- Head outputs:
  - instr_out/pc2_out come combinationally from the entry at the head pointer when count>0.
  - Otherwise they show NOP_INSTR / 0.
  - valid_out = (count != 0).
- Latency: an entry pushed at edge N is visible at the head after edge N if the buffer was empty at edge N. Fetch-to-decode latency is 1 cycle.
- Simultaneous push and pop while empty: not possible, since pop requires valid_out=1.
- HALT detection:
  - An accepted push with instr_in[15:11]==5'b00000 sets halt_seen at that edge.
  - From the next cycle, push=0 and pcWrite=0 until flush or reset.
  - Entries already buffered, including the HALT itself, still drain normally to decode.
- Flush has priority over every other input:
  - At the edge it clears the pointers, count and halt_seen.
  - No push or pop occurs that cycle and pcWrite=0.
  - From the next cycle, valid_out=0.
- flush and reset held high/low for multiple cycles have the same effect as a single cycle; state remains empty.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.

Optional Feature:
- Macro: IFID_STATS_EN.
- Defined: stall_cnt is a 16-bit counter.
  - Increments on each cycle with fetch_valid=1, halt_seen=0, flush=0 and push=0.
  - Saturates at 16'hFFFF.
  - Clears on reset only (not on flush).
- Not defined: stall_cnt is tied to 16'h0000 and no counter logic is instantiated.

Test Plan:
- Reset then idle, fetch_valid=0 -> valid_out=0, instr_out=16'h0800, pc2_out=0, count=0, pcWrite=0.
- Stream A000/0002, A001/0004, A002/0006 with dec_ready=1 every cycle -> pcWrite=1 every cycle, count stays 1, decode sees each instr one cycle after push, in order.
- dec_ready=0 with 3 pushes offered -> first two accepted (count=2, pcWrite=1,1), third cycle pcWrite=0. Then dec_ready=1 -> pop A000 and push third in the same cycle, count stays 2.
- Buffer holds 2 entries, flush=1 with fetch_valid=1 and dec_ready=1 -> pcWrite=0 that cycle, next cycle count=0, valid_out=0, instr_out=16'h0800.
- Push 16'h0000 (HALT) at pc2 16'h0010, then keep fetch_valid=1 -> halt_seen=1, pcWrite=0 thereafter. HALT drains to decode. A subsequent flush clears halt_seen and pushes resume.
- With IFID_STATS_EN defined: full buffer, dec_ready=0, fetch_valid=1 for 5 cycles -> stall_cnt=5. Mid-stream rst pulse -> all state cleared, stall_cnt=0.

Source files
------------

// File: rtl/if_id_buf.sv
// IF/ID instruction buffer: a DEPTH-entry circular FIFO of {instr, pc2} between fetch and decode.
// Optional stall statistic counter enabled by defining IFID_STATS_EN.
module if_id_buf #(
    parameter int unsigned DEPTH     = 2,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [15:0]              instr_in,
    input  logic [15:0]              pc2_in,
    input  logic                     fetch_valid,
    input  logic                     flush,
    input  logic                     dec_ready,
    output logic                     pcWrite,
    output logic [15:0]              instr_out,
    output logic [15:0]              pc2_out,
    output logic                     valid_out,
    output logic                     halt_seen,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              stall_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] Full = CW'(DEPTH);

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          halt_q, halt_d;
    logic          push, pop;

    logic [15:0] instr_mem [DEPTH];
    logic [15:0] pc2_mem [DEPTH];

    assign valid_out = (count_q != '0);
    assign instr_out = valid_out ? instr_mem[rptr_q] : NOP_INSTR;
    assign pc2_out   = valid_out ? pc2_mem[rptr_q] : 16'h0000;
    assign pcWrite   = push;
    assign halt_seen = halt_q;
    assign count     = count_q;

    always_comb begin
        pop     = valid_out & dec_ready & ~flush;
        // A full buffer may still accept when the head leaves in the same cycle.
        push    = fetch_valid & ~halt_q & ~flush & ((count_q < Full) | pop);
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        halt_d  = halt_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            halt_d  = 1'b0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + PW'(1);
                if (instr_in[15:11] == 5'b00000) begin
                    halt_d = 1'b1;
                end
            end
            if (pop) begin
                rptr_d = rptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            halt_q  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            halt_q  <= halt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wptr_q] <= instr_in;
            pc2_mem[wptr_q]   <= pc2_in;
        end
    end

`ifdef IFID_STATS_EN
    logic [15:0] stall_q, stall_d;

    // Counts cycles where fetch had a live instruction that the buffer refused.
    always_comb begin
        stall_d = stall_q;
        if (fetch_valid && !halt_q && !flush && !push && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_if_id_buf.sv
// Scoreboard bench for if_id_buf: stimulus queues expected decode entries, a monitor checks pops.
module tb_if_id_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr_in;
    logic [15:0] pc2_in;
    logic        fetch_valid;
    logic        flush;
    logic        dec_ready;
    logic        pcWrite;
    logic [15:0] instr_out;
    logic [15:0] pc2_out;
    logic        valid_out;
    logic        halt_seen;
    logic [1:0]  count;
    logic [15:0] stall_cnt;

    int checks = 0;
    int passes = 0;
    logic [31:0] sb[$];

    if_id_buf #(
        .DEPTH    (2),
        .NOP_INSTR(16'h0800)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .instr_in   (instr_in),
        .pc2_in     (pc2_in),
        .fetch_valid(fetch_valid),
        .flush      (flush),
        .dec_ready  (dec_ready),
        .pcWrite    (pcWrite),
        .instr_out  (instr_out),
        .pc2_out    (pc2_out),
        .valid_out  (valid_out),
        .halt_seen  (halt_seen),
        .count      (count),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Inputs change 1 unit after the rising edge; checks happen on the falling edge.
    task automatic step(input logic fv, input logic [15:0] ins, input logic [15:0] pc,
                        input logic dr, input logic fl);
        @(posedge clk);
        #1;
        fetch_valid = fv;
        instr_in    = ins;
        pc2_in      = pc;
        dec_ready   = dr;
        flush       = fl;
        @(negedge clk);
    endtask

    task automatic expect_pop(input logic [15:0] ins, input logic [15:0] pc);
        sb.push_back({ins, pc});
    endtask

    // Monitor: every head consumption is compared against the oldest expected entry.
    always @(negedge clk) begin
        if (rst && valid_out && dec_ready && !flush) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL pop_unexpected: got %h/%h expected no entry", instr_out, pc2_out);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                chk("pop_instr", {16'h0, instr_out}, {16'h0, e[31:16]});
                chk("pop_pc2", {16'h0, pc2_out}, {16'h0, e[15:0]});
            end
        end
    end

    initial begin
        rst = 1'b0;
        fetch_valid = 1'b0;
        instr_in = '0;
        pc2_in = '0;
        dec_ready = 1'b0;
        flush = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Reset / idle
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("rst_valid", {31'h0, valid_out}, 32'h0);
        chk("rst_instr", {16'h0, instr_out}, 32'h0800);
        chk("rst_pc2", {16'h0, pc2_out}, 32'h0);
        chk("rst_count", {30'h0, count}, 32'h0);
        chk("rst_pcwrite", {31'h0, pcWrite}, 32'h0);
        chk("rst_halt", {31'h0, halt_seen}, 32'h0);
        chk("rst_stall", {16'h0, stall_cnt}, 32'h0);

        // Streaming with decode always ready
        step(1'b1, 16'hA000, 16'h0002, 1'b1, 1'b0);
        expect_pop(16'hA000, 16'h0002);
        chk("strm_pw0", {31'h0, pcWrite}, 32'h1);
        chk("strm_cnt0", {30'h0, count}, 32'h0);
        step(1'b1, 16'hA001, 16'h0004, 1'b1, 1'b0);
        expect_pop(16'hA001, 16'h0004);
        chk("strm_pw1", {31'h0, pcWrite}, 32'h1);
        chk("strm_cnt1", {30'h0, count}, 32'h1);
        step(1'b1, 16'hA002, 16'h0006, 1'b1, 1'b0);
        expect_pop(16'hA002, 16'h0006);
        chk("strm_pw2", {31'h0, pcWrite}, 32'h1);
        chk("strm_cnt2", {30'h0, count}, 32'h1);
        step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        chk("strm_pw3", {31'h0, pcWrite}, 32'h0);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("strm_empty", {31'h0, valid_out}, 32'h0);

        // Decode stall fills the buffer, then pop+push on a full buffer
        step(1'b1, 16'hB000, 16'h0102, 1'b0, 1'b0);
        expect_pop(16'hB000, 16'h0102);
        chk("full_pw0", {31'h0, pcWrite}, 32'h1);
        step(1'b1, 16'hB001, 16'h0104, 1'b0, 1'b0);
        expect_pop(16'hB001, 16'h0104);
        chk("full_pw1", {31'h0, pcWrite}, 32'h1);
        step(1'b1, 16'hB002, 16'h0106, 1'b0, 1'b0);
        chk("full_pw2", {31'h0, pcWrite}, 32'h0);
        chk("full_cnt", {30'h0, count}, 32'h2);
        step(1'b1, 16'hB002, 16'h0106, 1'b1, 1'b0);
        expect_pop(16'hB002, 16'h0106);
        chk("full_pushpop_pw", {31'h0, pcWrite}, 32'h1);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("full_pushpop_cnt", {30'h0, count}, 32'h2);
        chk("full_head", {16'h0, instr_out}, 32'hB001);

        // Flush while holding two entries
        step(1'b1, 16'hC000, 16'h0200, 1'b1, 1'b1);
        chk("flush_pw", {31'h0, pcWrite}, 32'h0);
        sb.delete();
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("flush_cnt", {30'h0, count}, 32'h0);
        chk("flush_valid", {31'h0, valid_out}, 32'h0);
        chk("flush_instr", {16'h0, instr_out}, 32'h0800);

        // HALT blocks further pushes, still drains, and flush releases it
        step(1'b1, 16'h0000, 16'h0010, 1'b0, 1'b0);
        expect_pop(16'h0000, 16'h0010);
        chk("halt_pw0", {31'h0, pcWrite}, 32'h1);
        step(1'b1, 16'hD000, 16'h0012, 1'b0, 1'b0);
        chk("halt_seen", {31'h0, halt_seen}, 32'h1);
        chk("halt_pw1", {31'h0, pcWrite}, 32'h0);
        step(1'b1, 16'hD000, 16'h0012, 1'b1, 1'b0);
        chk("halt_pw2", {31'h0, pcWrite}, 32'h0);
        step(1'b1, 16'hD000, 16'h0012, 1'b1, 1'b0);
        chk("halt_drained", {30'h0, count}, 32'h0);
        chk("halt_pw3", {31'h0, pcWrite}, 32'h0);
        step(1'b1, 16'hD000, 16'h0012, 1'b0, 1'b1);
        chk("halt_flush_pw", {31'h0, pcWrite}, 32'h0);
        step(1'b1, 16'hD000, 16'h0012, 1'b0, 1'b0);
        expect_pop(16'hD000, 16'h0012);
        chk("halt_cleared", {31'h0, halt_seen}, 32'h0);
        chk("halt_resume_pw", {31'h0, pcWrite}, 32'h1);
        step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        chk("resume_cnt", {30'h0, count}, 32'h1);

        // Clean reset, fill, five refused fetches, then asynchronous reset mid-stream
        rst = 1'b0;
        #1;
        rst = 1'b1;
        step(1'b1, 16'hE000, 16'h0302, 1'b0, 1'b0);
        expect_pop(16'hE000, 16'h0302);
        step(1'b1, 16'hE001, 16'h0304, 1'b0, 1'b0);
        expect_pop(16'hE001, 16'h0304);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 16'hE002, 16'h0306, 1'b0, 1'b0);
        end
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("stall_full_cnt", {30'h0, count}, 32'h2);
`ifdef IFID_STATS_EN
        chk("stall_cnt5", {16'h0, stall_cnt}, 32'h5);
`else
        chk("stall_cnt_tied", {16'h0, stall_cnt}, 32'h0);
`endif
        rst = 1'b0;
        sb.delete();
        #1;
        chk("arst_cnt", {30'h0, count}, 32'h0);
        chk("arst_valid", {31'h0, valid_out}, 32'h0);
        chk("arst_instr", {16'h0, instr_out}, 32'h0800);
        chk("arst_stall", {16'h0, stall_cnt}, 32'h0);
        #1;
        rst = 1'b1;
        step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        chk("post_rst_cnt", {30'h0, count}, 32'h0);
        chk("sb_drained", sb.size(), 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
